// File: rtl/ctc_timer.sv
// Two-channel 16-bit down-counting counter/timer peripheral on the CPU IO bus.
// Optional interrupt output and mode bit2 enable are built when CTC_IRQ_EN is defined.
module ctc_timer #(
   parameter int PRESCALE    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctccs,
   input  logic        ctcread,
   input  logic        ctcwrite,
   input  logic [2:0]  ctcaddr,
   input  logic [15:0] ctcwdata,
   output logic [15:0] ctcrdata,
   input  logic        pulse0,
   input  logic        pulse1,
`ifdef CTC_IRQ_EN
   output logic        irq,
`endif
   output logic        cout0,
   output logic        cout1
);

`ifdef CTC_IRQ_EN
   localparam int MW = 3;
`else
   localparam int MW = 2;
`endif
   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [MW-1:0]          mode_q  [2];
   logic [MW-1:0]          mode_d  [2];
   logic [15:0]            init_q  [2];
   logic [15:0]            init_d  [2];
   logic [15:0]            count_q [2];
   logic [15:0]            count_d [2];
   logic [15:0]            pre_q   [2];
   logic [15:0]            pre_d   [2];
   logic [SYNC_STAGES-1:0] sync_q  [2];
   logic [SYNC_STAGES-1:0] sync_d  [2];
   logic                   run_q   [2];
   logic                   run_d   [2];
   logic                   done_q  [2];
   logic                   done_d  [2];
   logic                   cout_q  [2];
   logic                   cout_d  [2];
   logic                   prev_q  [2];
   logic                   prev_d  [2];

   logic pulseIn [2];
   logic wrMode  [2];
   logic wrInit  [2];
   logic rdStat  [2];
   logic tick    [2];
   logic wrEn;
   logic rdEn;
   logic unusedAddr;

   assign wrEn       = ctccs & ctcwrite;
   assign rdEn       = ctccs & ctcread;
   assign unusedAddr = ctcaddr[0];
   assign pulseIn[0] = pulse0;
   assign pulseIn[1] = pulse1;
   assign wrMode[0]  = wrEn & ~ctcaddr[2] & ~ctcaddr[1];
   assign wrMode[1]  = wrEn & ~ctcaddr[2] &  ctcaddr[1];
   assign wrInit[0]  = wrEn &  ctcaddr[2] & ~ctcaddr[1];
   assign wrInit[1]  = wrEn &  ctcaddr[2] &  ctcaddr[1];
   assign rdStat[0]  = rdEn & ~ctcaddr[2] & ~ctcaddr[1];
   assign rdStat[1]  = rdEn & ~ctcaddr[2] &  ctcaddr[1];
   assign cout0      = cout_q[0];
   assign cout1      = cout_q[1];

   // Counter mode ticks on a synchronised rising edge, timer mode on prescale wrap.
   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         tick[ch] = mode_q[ch][0] ? (sync_q[ch][SYNC_STAGES-1] & ~prev_q[ch])
                                  : (pre_q[ch] == PRE_LAST);
      end
   end

   // Bus writes take priority over ticks; a status read clears done unless a tick sets it.
   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         mode_d[ch]  = mode_q[ch];
         init_d[ch]  = init_q[ch];
         count_d[ch] = count_q[ch];
         pre_d[ch]   = pre_q[ch];
         run_d[ch]   = run_q[ch];
         done_d[ch]  = done_q[ch];
         cout_d[ch]  = 1'b0;
         sync_d[ch]  = {sync_q[ch][SYNC_STAGES-2:0], pulseIn[ch]};
         prev_d[ch]  = sync_q[ch][SYNC_STAGES-1];
         if (rdStat[ch]) begin
            done_d[ch] = 1'b0;
         end
         if (wrInit[ch]) begin
            init_d[ch]  = ctcwdata;
            count_d[ch] = ctcwdata;
            done_d[ch]  = 1'b0;
            pre_d[ch]   = 16'd0;
            run_d[ch]   = |ctcwdata;
         end else if (wrMode[ch]) begin
            mode_d[ch] = ctcwdata[MW-1:0];
            run_d[ch]  = 1'b0;
         end else if (run_q[ch]) begin
            if (!mode_q[ch][0]) begin
               pre_d[ch] = (pre_q[ch] == PRE_LAST) ? 16'd0 : pre_q[ch] + 16'd1;
            end
            if (tick[ch]) begin
               if (count_q[ch] == 16'd1) begin
                  done_d[ch] = 1'b1;
                  cout_d[ch] = 1'b1;
                  if (mode_q[ch][1]) begin
                     count_d[ch] = init_q[ch];
                  end else begin
                     count_d[ch] = 16'd0;
                     run_d[ch]   = 1'b0;
                  end
               end else begin
                  count_d[ch] = count_q[ch] - 16'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (reset) begin
            mode_q[ch]  <= '0;
            init_q[ch]  <= '0;
            count_q[ch] <= '0;
            pre_q[ch]   <= '0;
            sync_q[ch]  <= '0;
            run_q[ch]   <= 1'b0;
            done_q[ch]  <= 1'b0;
            cout_q[ch]  <= 1'b0;
            prev_q[ch]  <= 1'b0;
         end else begin
            mode_q[ch]  <= mode_d[ch];
            init_q[ch]  <= init_d[ch];
            count_q[ch] <= count_d[ch];
            pre_q[ch]   <= pre_d[ch];
            sync_q[ch]  <= sync_d[ch];
            run_q[ch]   <= run_d[ch];
            done_q[ch]  <= done_d[ch];
            cout_q[ch]  <= cout_d[ch];
            prev_q[ch]  <= prev_d[ch];
         end
      end
   end

`ifdef CTC_IRQ_EN
   logic irq_q;
   assign irq = irq_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (done_q[0] & mode_q[0][2]) | (done_q[1] & mode_q[1][2]);
      end
   end
`endif

   always_comb begin
      ctcrdata = 16'h0000;
      if (rdEn) begin
         case (ctcaddr[2:1])
            2'b00:   ctcrdata = {14'b0, run_q[0], done_q[0]};
            2'b01:   ctcrdata = {14'b0, run_q[1], done_q[1]};
            2'b10:   ctcrdata = count_q[0];
            default: ctcrdata = count_q[1];
         endcase
      end
   end

endmodule

// File: tb/tb_ctc_timer.sv
// Self-checking bench for ctc_timer: directed scenarios plus a randomized run
// against a behavioural model of the register map, tick rules and collisions.
module tb_ctc_timer;

   localparam int SYNC     = 2;
   localparam int PRE_MAIN = 1;
   localparam int PRE_ALT  = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctccs = 1'b0;
   logic        ctcread = 1'b0;
   logic        ctcwrite = 1'b0;
   logic [2:0]  ctcaddr = 3'd0;
   logic [15:0] ctcwdata = 16'd0;
   logic        pulse0 = 1'b0;
   logic        pulse1 = 1'b0;
   logic [15:0] ctcrdata;
   logic [15:0] rdataP;
   logic        cout0, cout1, cout0P, cout1P;

   int checks = 0;
   int errors = 0;

   ctc_timer #(.PRESCALE(PRE_MAIN), .SYNC_STAGES(SYNC)) dut (
      .clock(clock), .reset(reset), .ctccs(ctccs), .ctcread(ctcread),
      .ctcwrite(ctcwrite), .ctcaddr(ctcaddr), .ctcwdata(ctcwdata),
      .ctcrdata(ctcrdata), .pulse0(pulse0), .pulse1(pulse1),
      .cout0(cout0), .cout1(cout1));

   ctc_timer #(.PRESCALE(PRE_ALT), .SYNC_STAGES(SYNC)) dutP (
      .clock(clock), .reset(reset), .ctccs(ctccs), .ctcread(ctcread),
      .ctcwrite(ctcwrite), .ctcaddr(ctcaddr), .ctcwdata(ctcwdata),
      .ctcrdata(rdataP), .pulse0(pulse0), .pulse1(pulse1),
      .cout0(cout0P), .cout1(cout1P));

   always #5 clock = ~clock;

   // Reference model state for the randomized run on the PRESCALE=1 instance.
   logic [1:0]  mMode  [2];
   logic [15:0] mInit  [2];
   logic [15:0] mCount [2];
   logic [15:0] mPre   [2];
   logic        mRun   [2];
   logic        mDone  [2];
   logic        mCout  [2];
   logic [7:0]  mHist  [2];

   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1; ctccs = 1'b0; ctcread = 1'b0; ctcwrite = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic busWrite(input logic [2:0] a, input logic [15:0] d);
      @(negedge clock);
      ctccs = 1'b1; ctcwrite = 1'b1; ctcread = 1'b0; ctcaddr = a; ctcwdata = d;
      @(posedge clock); #1;
      ctccs = 1'b0; ctcwrite = 1'b0;
   endtask

   task automatic busRead(input logic [2:0] a, output logic [15:0] d);
      @(negedge clock);
      ctccs = 1'b1; ctcread = 1'b1; ctcwrite = 1'b0; ctcaddr = a;
      #1 d = ctcrdata;
      @(posedge clock); #1;
      ctccs = 1'b0; ctcread = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      logic [15:0] v;
      applyReset();
      checks++;
      if ({cout1, cout0} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_cout got %b expected 00", {cout1, cout0});
      end
      for (int a = 0; a < 8; a += 2) begin
         busRead(3'(a), v);
         checkOutput("reset_read", v, 16'h0000);
      end
   endtask

   task automatic test_oneshot();
      logic [15:0] v;
      applyReset();
      busWrite(3'd0, 16'h0000);
      busWrite(3'd4, 16'd3);
      for (int i = 0; i < 3; i++) begin
         busRead(3'd4, v);
         checkOutput("oneshot_count", v, 16'(3 - i));
      end
      checkOutput("oneshot_cout_high", {15'b0, cout0}, 16'd1);
      busRead(3'd0, v);
      checkOutput("oneshot_status_done", v, 16'h0001);
      checkOutput("oneshot_cout_low", {15'b0, cout0}, 16'd0);
      busRead(3'd0, v);
      checkOutput("oneshot_status_cleared", v, 16'h0000);
      busRead(3'd4, v);
      checkOutput("oneshot_count_zero", v, 16'h0000);
   endtask

   task automatic test_repeat();
      logic [15:0] v;
      int pulses = 0;
      applyReset();
      busWrite(3'd2, 16'd2);
      busWrite(3'd6, 16'd2);
      repeat (10) begin
         @(posedge clock); #1;
         if (cout1) pulses++;
      end
      checkOutput("repeat_pulses", 16'(pulses), 16'd5);
      busRead(3'd2, v);
      checkOutput("repeat_status", v, 16'h0003);
   endtask

   task automatic test_counter();
      logic [15:0] v;
      applyReset();
      busWrite(3'd0, 16'd1);
      busWrite(3'd4, 16'd2);
      @(negedge clock) pulse0 = 1'b1;
      repeat (2) @(posedge clock);
      busRead(3'd4, v);
      checkOutput("counter_before_latency", v, 16'd2);
      busRead(3'd4, v);
      checkOutput("counter_first_edge", v, 16'd1);
      @(negedge clock) pulse0 = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock) pulse0 = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("counter_cout", {15'b0, cout0}, 16'd1);
      busRead(3'd0, v);
      checkOutput("counter_status", v, 16'h0001);
      @(negedge clock) pulse0 = 1'b0;
   endtask

   task automatic test_collisions();
      logic [15:0] v;
      applyReset();
      busWrite(3'd0, 16'h0000);
      busWrite(3'd4, 16'd2);
      busRead(3'd4, v);
      busWrite(3'd4, 16'd5);
      checkOutput("coll_init_no_cout", {15'b0, cout0}, 16'd0);
      busRead(3'd4, v);
      checkOutput("coll_init_count", v, 16'd5);
      busRead(3'd0, v);
      checkOutput("coll_init_status", v, 16'h0002);
      busWrite(3'd4, 16'd2);
      busRead(3'd4, v);
      busRead(3'd0, v);
      checkOutput("coll_read_pre_edge", v, 16'h0002);
      checkOutput("coll_read_cout", {15'b0, cout0}, 16'd1);
      busRead(3'd0, v);
      checkOutput("coll_read_done_kept", v, 16'h0001);
      busWrite(3'd4, 16'd2);
      busRead(3'd4, v);
      busWrite(3'd0, 16'h0000);
      checkOutput("coll_mode_no_cout", {15'b0, cout0}, 16'd0);
      busRead(3'd4, v);
      checkOutput("coll_mode_count_held", v, 16'd1);
      busRead(3'd0, v);
      checkOutput("coll_mode_status", v, 16'h0000);
   endtask

   task automatic test_midreset();
      logic [15:0] v;
      applyReset();
      busWrite(3'd2, 16'h0000);
      busWrite(3'd6, 16'd9);
      busRead(3'd6, v);
      busRead(3'd6, v);
      checkOutput("midreset_pre_count", v, 16'd8);
      applyReset();
      checkOutput("midreset_cout", {15'b0, cout1}, 16'd0);
      busRead(3'd6, v);
      checkOutput("midreset_count", v, 16'd0);
      busRead(3'd2, v);
      checkOutput("midreset_status", v, 16'h0000);
      repeat (5) @(posedge clock);
      busRead(3'd6, v);
      checkOutput("midreset_idle_count", v, 16'd0);
   endtask

   task automatic test_prescale();
      applyReset();
      busWrite(3'd0, 16'h0000);
      busWrite(3'd4, 16'd2);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         ctccs = 1'b1; ctcread = 1'b1; ctcaddr = 3'd4;
         #1 checkOutput("prescale_count", rdataP, 16'(2 - i / PRE_ALT));
         @(posedge clock);
      end
      #1;
      ctccs = 1'b0; ctcread = 1'b0;
      checkOutput("prescale_cout", {14'b0, cout1P, cout0P}, 16'b01);
   endtask

   function automatic logic [15:0] modelRead(input logic [2:0] a);
      case (a[2:1])
         2'b00:   return {14'b0, mRun[0], mDone[0]};
         2'b01:   return {14'b0, mRun[1], mDone[1]};
         2'b10:   return mCount[0];
         default: return mCount[1];
      endcase
   endfunction

   task automatic modelClear();
      for (int ch = 0; ch < 2; ch++) begin
         mMode[ch] = '0; mInit[ch] = '0; mCount[ch] = '0; mPre[ch] = '0;
         mRun[ch] = 1'b0; mDone[ch] = 1'b0; mCout[ch] = 1'b0; mHist[ch] = '0;
      end
   endtask

   // Advance the model by one clock edge using the bus and pulse values seen at that edge.
   task automatic modelStep(input logic cs, input logic rd, input logic wr,
                            input logic [2:0] a, input logic [15:0] wd,
                            input logic p0, input logic p1);
      logic p [2];
      logic isMine, rising, timerDue;
      p[0] = p0; p[1] = p1;
      for (int ch = 0; ch < 2; ch++) begin
         isMine = (int'(a[1]) == ch);
         mHist[ch] = {mHist[ch][6:0], p[ch]};
         rising   = mHist[ch][SYNC] && !mHist[ch][SYNC+1];
         timerDue = (int'(mPre[ch]) == PRE_MAIN - 1);
         mCout[ch] = 1'b0;
         if (cs && rd && !a[2] && isMine) mDone[ch] = 1'b0;
         if (cs && wr && a[2] && isMine) begin
            mInit[ch] = wd; mCount[ch] = wd; mDone[ch] = 1'b0;
            mPre[ch] = 16'd0; mRun[ch] = (wd != 0);
         end else if (cs && wr && isMine) begin
            mMode[ch] = wd[1:0]; mRun[ch] = 1'b0;
         end else if (mRun[ch]) begin
            if (!mMode[ch][0]) mPre[ch] = timerDue ? 16'd0 : mPre[ch] + 16'd1;
            if (mMode[ch][0] ? rising : timerDue) begin
               if (mCount[ch] == 1) begin
                  mDone[ch] = 1'b1; mCout[ch] = 1'b1;
                  if (mMode[ch][1]) mCount[ch] = mInit[ch];
                  else begin mCount[ch] = 16'd0; mRun[ch] = 1'b0; end
               end else begin
                  mCount[ch] = mCount[ch] - 16'd1;
               end
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] expRd;
      logic        doReset;
      applyReset();
      modelClear();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clock);
         doReset  = ($urandom_range(0, 199) == 0);
         reset    = doReset;
         ctccs    = ($urandom_range(0, 7) != 0);
         ctcread  = $urandom_range(0, 1) == 1;
         ctcwrite = ($urandom_range(0, 3) == 0);
         ctcaddr  = 3'($urandom_range(0, 7));
         ctcwdata = ctcaddr[2] ? 16'($urandom_range(0, 5)) : 16'($urandom);
         if ($urandom_range(0, 3) == 0) pulse0 = ~pulse0;
         if ($urandom_range(0, 3) == 0) pulse1 = ~pulse1;
         #1;
         expRd = (ctccs && ctcread) ? modelRead(ctcaddr) : 16'h0000;
         checkOutput("random_rdata", ctcrdata, expRd);
         @(posedge clock);
         if (doReset) modelClear();
         else modelStep(ctccs, ctcread, ctcwrite, ctcaddr, ctcwdata, pulse0, pulse1);
         #1;
         checkOutput("random_cout", {14'b0, cout1, cout0}, {14'b0, mCout[1], mCout[0]});
      end
      reset = 1'b0; ctccs = 1'b0; ctcread = 1'b0; ctcwrite = 1'b0;
   endtask

   // Directed scenarios first, then the randomized model comparison.
   initial begin
      test_reset();
      test_oneshot();
      test_repeat();
      test_counter();
      test_collisions();
      test_midreset();
      test_prescale();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
